// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard controller for the 5-stage TCORE pipe (FE/DE/EX/ME/WB):
//           EX/DE forwarding, load-use stall, long-op scoreboard, structural and memory
//           stalls, redirect flush, stall watchdog and optional perf counters.
// Latency : forward/stall/flush outputs are combinational (0 cycles); scoreboard
//           updates become visible next cycle (a completing op is masked the same cycle).
// Backpressure: mem_stall_i freezes every stage and suppresses flushes; DE-side hazards
//           hold FE/DE and inject a bubble into EX.
//
// Build option: define HAZARD_PERF_EN to get the stall/flush cycle counters; when it is
// not defined both counter ports are tied to zero and no counter flops exist.
//
// Port summary:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   *_de_i                       DE sources/destination, RF-write and long-op flags
//   *_ex_i                       EX sources/destination, load flag, redirect
//   rd_addr_me_i/rf_rw_me_i      ME writeback target
//   rd_addr_wb_i/rf_rw_wb_i      WB writeback target
//   lop_issue*/lop_done*         long-op unit issue and completion, lop_busy_i structural
//   mem_stall_i                  data memory not ready (global freeze)
//   stall_*_o, flush_*_o         stage holds and bubble inserts
//   fwd_*_ex_o                   00 RF, 01 WB, 10 ME;  fwd_*_de_o WB-to-DE bypass
//   hazard_timeout_o             sticky watchdog flag
//   stall_cycles_o/flush_cycles_o perf counters

module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int WDOG_W     = 8,
    parameter int WDOG_LIMIT = 200
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [REG_AW-1:0] r1_addr_de_i,
    input  logic [REG_AW-1:0] r2_addr_de_i,
    input  logic [REG_AW-1:0] rd_addr_de_i,
    input  logic              rf_rw_de_i,
    input  logic              lop_de_i,

    input  logic [REG_AW-1:0] r1_addr_ex_i,
    input  logic [REG_AW-1:0] r2_addr_ex_i,
    input  logic [REG_AW-1:0] rd_addr_ex_i,
    input  logic              load_ex_i,
    input  logic              pc_sel_ex_i,

    input  logic [REG_AW-1:0] rd_addr_me_i,
    input  logic              rf_rw_me_i,

    input  logic [REG_AW-1:0] rd_addr_wb_i,
    input  logic              rf_rw_wb_i,

    input  logic              lop_issue_i,
    input  logic [REG_AW-1:0] lop_issue_rd_i,
    input  logic              lop_done_i,
    input  logic [REG_AW-1:0] lop_done_rd_i,
    input  logic              lop_busy_i,

    input  logic              mem_stall_i,

    output logic              stall_fe_o,
    output logic              stall_de_o,
    output logic              stall_ex_o,
    output logic              stall_me_o,
    output logic              flush_de_o,
    output logic              flush_ex_o,
    output logic [1:0]        fwd_a_ex_o,
    output logic [1:0]        fwd_b_ex_o,
    output logic              fwd_a_de_o,
    output logic              fwd_b_de_o,
    output logic              hazard_timeout_o,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       flush_cycles_o
);

    localparam int NREG = 1 << REG_AW;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_ME = 2'b10;

    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_LIMIT[WDOG_W-1:0];

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------

    // ME is the younger producer, so it wins over WB. x0 is hardwired
    // zero and must always read from the register file.
    function automatic logic [1:0] ex_fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] rd_me,
        input logic              rw_me,
        input logic [REG_AW-1:0] rd_wb,
        input logic              rw_wb
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (rw_me && (rd_me == src)) begin
                sel = FWD_ME;
            end else if (rw_wb && (rd_wb == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    function automatic logic de_fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] rd_wb,
        input logic              rw_wb
    );
        return rw_wb && (src != '0) && (rd_wb == src);
    endfunction

    always_comb begin
        fwd_a_ex_o = ex_fwd_sel(r1_addr_ex_i, rd_addr_me_i, rf_rw_me_i, rd_addr_wb_i, rf_rw_wb_i);
        fwd_b_ex_o = ex_fwd_sel(r2_addr_ex_i, rd_addr_me_i, rf_rw_me_i, rd_addr_wb_i, rf_rw_wb_i);
        fwd_a_de_o = de_fwd_sel(r1_addr_de_i, rd_addr_wb_i, rf_rw_wb_i);
        fwd_b_de_o = de_fwd_sel(r2_addr_de_i, rd_addr_wb_i, rf_rw_wb_i);
    end

    // ------------------------------------------------------------------
    // Long-op scoreboard
    // ------------------------------------------------------------------

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_v;
    logic [NREG-1:0] issue_mask;
    logic [NREG-1:0] done_mask;

    always_comb begin
        issue_mask = '0;
        done_mask  = '0;
        if (lop_issue_i && (lop_issue_rd_i != '0)) begin
            issue_mask[lop_issue_rd_i] = 1'b1;
        end
        if (lop_done_i) begin
            done_mask[lop_done_rd_i] = 1'b1;
        end
    end

    // The completing result is already on the WB bypass this cycle, so the
    // stall view drops it immediately instead of waiting for the flop.
    assign pend_v = pend_q & ~done_mask;

    // Clear first, then set: a new issue to a register whose previous op is
    // completing in the same cycle must stay pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~done_mask) | issue_mask;
        end
    end

    // ------------------------------------------------------------------
    // Stall sources
    // ------------------------------------------------------------------

    logic lu_stall;
    logic sb_raw;
    logic sb_waw;
    logic sb_stall;
    logic st_stall;
    logic de_stall;

    always_comb begin
        lu_stall = load_ex_i && (rd_addr_ex_i != '0) &&
                   ((rd_addr_ex_i == r1_addr_de_i) || (rd_addr_ex_i == r2_addr_de_i));

        // pend_q[0] can never be set, so x0 needs no explicit guard here.
        sb_raw   = pend_v[r1_addr_de_i] || pend_v[r2_addr_de_i];
        sb_waw   = rf_rw_de_i && pend_v[rd_addr_de_i];
        sb_stall = sb_raw || sb_waw;

        st_stall = lop_de_i && lop_busy_i;

        de_stall = lu_stall || sb_stall || st_stall;
    end

    // ------------------------------------------------------------------
    // Stage enables and flushes
    // ------------------------------------------------------------------

    // During a memory freeze the datapath holds pc_sel_ex, so the redirect
    // is simply deferred until the freeze lifts; flushing now would lose it.
    // When a redirect coincides with a DE stall, DE still holds but its
    // content is squashed by the flush, so the hold is harmless.
    always_comb begin
        if (mem_stall_i) begin
            stall_fe_o = 1'b1;
            stall_de_o = 1'b1;
            stall_ex_o = 1'b1;
            stall_me_o = 1'b1;
            flush_de_o = 1'b0;
            flush_ex_o = 1'b0;
        end else begin
            stall_fe_o = de_stall;
            stall_de_o = de_stall;
            stall_ex_o = 1'b0;
            stall_me_o = 1'b0;
            flush_de_o = pc_sel_ex_i;
            flush_ex_o = de_stall || pc_sel_ex_i;
        end
    end

    // ------------------------------------------------------------------
    // Stall watchdog
    // ------------------------------------------------------------------

    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_nxt;
    logic              timeout_q;

    // Saturating increment so a very long hang cannot wrap back below the limit.
    assign wdog_nxt = (&wdog_q) ? wdog_q : (wdog_q + 1'b1);

    // The flag is raised on the same edge that brings the count to the limit,
    // so it is visible in the cycle right after the limit-th stall cycle.
    // A memory freeze is not a DE hazard, so the count neither advances nor
    // clears while it is active.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (!mem_stall_i) begin
            if (de_stall) begin
                wdog_q <= wdog_nxt;
                if (wdog_nxt >= WDOG_LIM) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wdog_q <= '0;
            end
        end
    end

    assign hazard_timeout_o = timeout_q;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_de_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_de_o) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_cycles_o = flush_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign flush_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : directed bench for hazard_ctrl with a behavioural reference model.
// Latency : model checked every negedge; literal checks 1 ns after inputs change.
// Backpressure: mem_stall freeze and redirect interplay exercised directly.

module tb_hazard_ctrl;

    localparam int LIM = 10;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  r1_addr_de_i, r2_addr_de_i, rd_addr_de_i;
    logic        rf_rw_de_i, lop_de_i;
    logic [4:0]  r1_addr_ex_i, r2_addr_ex_i, rd_addr_ex_i;
    logic        load_ex_i, pc_sel_ex_i;
    logic [4:0]  rd_addr_me_i;
    logic        rf_rw_me_i;
    logic [4:0]  rd_addr_wb_i;
    logic        rf_rw_wb_i;
    logic        lop_issue_i;
    logic [4:0]  lop_issue_rd_i;
    logic        lop_done_i;
    logic [4:0]  lop_done_rd_i;
    logic        lop_busy_i, mem_stall_i;

    logic        stall_fe_o, stall_de_o, stall_ex_o, stall_me_o;
    logic        flush_de_o, flush_ex_o;
    logic [1:0]  fwd_a_ex_o, fwd_b_ex_o;
    logic        fwd_a_de_o, fwd_b_de_o;
    logic        hazard_timeout_o;
    logic [31:0] stall_cycles_o, flush_cycles_o;

    hazard_ctrl #(.REG_AW(5), .WDOG_W(8), .WDOG_LIMIT(LIM)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .r1_addr_de_i(r1_addr_de_i), .r2_addr_de_i(r2_addr_de_i), .rd_addr_de_i(rd_addr_de_i),
        .rf_rw_de_i(rf_rw_de_i), .lop_de_i(lop_de_i),
        .r1_addr_ex_i(r1_addr_ex_i), .r2_addr_ex_i(r2_addr_ex_i), .rd_addr_ex_i(rd_addr_ex_i),
        .load_ex_i(load_ex_i), .pc_sel_ex_i(pc_sel_ex_i),
        .rd_addr_me_i(rd_addr_me_i), .rf_rw_me_i(rf_rw_me_i),
        .rd_addr_wb_i(rd_addr_wb_i), .rf_rw_wb_i(rf_rw_wb_i),
        .lop_issue_i(lop_issue_i), .lop_issue_rd_i(lop_issue_rd_i),
        .lop_done_i(lop_done_i), .lop_done_rd_i(lop_done_rd_i),
        .lop_busy_i(lop_busy_i), .mem_stall_i(mem_stall_i),
        .stall_fe_o(stall_fe_o), .stall_de_o(stall_de_o),
        .stall_ex_o(stall_ex_o), .stall_me_o(stall_me_o),
        .flush_de_o(flush_de_o), .flush_ex_o(flush_ex_o),
        .fwd_a_ex_o(fwd_a_ex_o), .fwd_b_ex_o(fwd_b_ex_o),
        .fwd_a_de_o(fwd_a_de_o), .fwd_b_de_o(fwd_b_de_o),
        .hazard_timeout_o(hazard_timeout_o),
        .stall_cycles_o(stall_cycles_o), .flush_cycles_o(flush_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit mpend [32];          // registers with an outstanding long op
    int mrun;                // length of the current unbroken DE-stall run
    bit mto;
    int mstalls, mflushes;

    function automatic bit pend_view(input logic [4:0] r);
        if (r == 0) return 1'b0;
        if (lop_done_i && lop_done_rd_i == r) return 1'b0;
        return mpend[r];
    endfunction

    function automatic bit m_de_stall();
        bit lu, sb, st;
        lu = load_ex_i && rd_addr_ex_i != 0 &&
             (rd_addr_ex_i == r1_addr_de_i || rd_addr_ex_i == r2_addr_de_i);
        sb = pend_view(r1_addr_de_i) || pend_view(r2_addr_de_i) ||
             (rf_rw_de_i && pend_view(rd_addr_de_i));
        st = lop_de_i && lop_busy_i;
        return lu || sb || st;
    endfunction

    function automatic logic [1:0] m_fwd_ex(input logic [4:0] s);
        if (s == 0) return 2'd0;
        if (rf_rw_me_i && rd_addr_me_i == s) return 2'd2;
        if (rf_rw_wb_i && rd_addr_wb_i == s) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit m_fwd_de(input logic [4:0] s);
        return rf_rw_wb_i && s != 0 && rd_addr_wb_i == s;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            foreach (mpend[i]) mpend[i] = 1'b0;
            mrun = 0; mto = 1'b0; mstalls = 0; mflushes = 0;
        end else begin
            bit ds;
            ds = m_de_stall();
            if (mem_stall_i || ds) mstalls++;
            if (!mem_stall_i && pc_sel_ex_i) mflushes++;
            if (!mem_stall_i) begin
                if (ds) begin
                    if (mrun < 255) mrun++;
                    if (mrun >= LIM) mto = 1'b1;
                end else begin
                    mrun = 0;
                end
            end
            if (lop_done_i) mpend[lop_done_rd_i] = 1'b0;
            if (lop_issue_i && lop_issue_rd_i != 0) mpend[lop_issue_rd_i] = 1'b1;
        end
    end

    always @(negedge clk_i) begin
        bit ds;
        logic [31:0] es, ef;
        ds = m_de_stall();
`ifdef HAZARD_PERF_EN
        es = mstalls; ef = mflushes;
`else
        es = 0; ef = 0;
`endif
        chk("m_stall_fe", {31'd0, stall_fe_o}, {31'd0, mem_stall_i | ds});
        chk("m_stall_de", {31'd0, stall_de_o}, {31'd0, mem_stall_i | ds});
        chk("m_stall_ex", {31'd0, stall_ex_o}, {31'd0, mem_stall_i});
        chk("m_stall_me", {31'd0, stall_me_o}, {31'd0, mem_stall_i});
        chk("m_flush_de", {31'd0, flush_de_o}, {31'd0, !mem_stall_i && pc_sel_ex_i});
        chk("m_flush_ex", {31'd0, flush_ex_o}, {31'd0, !mem_stall_i && (pc_sel_ex_i || ds)});
        chk("m_fwd_a_ex", {30'd0, fwd_a_ex_o}, {30'd0, m_fwd_ex(r1_addr_ex_i)});
        chk("m_fwd_b_ex", {30'd0, fwd_b_ex_o}, {30'd0, m_fwd_ex(r2_addr_ex_i)});
        chk("m_fwd_a_de", {31'd0, fwd_a_de_o}, {31'd0, m_fwd_de(r1_addr_de_i)});
        chk("m_fwd_b_de", {31'd0, fwd_b_de_o}, {31'd0, m_fwd_de(r2_addr_de_i)});
        chk("m_timeout", {31'd0, hazard_timeout_o}, {31'd0, mto});
        chk("m_stall_cnt", stall_cycles_o, es);
        chk("m_flush_cnt", flush_cycles_o, ef);
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        r1_addr_de_i = 0; r2_addr_de_i = 0; rd_addr_de_i = 0; rf_rw_de_i = 0; lop_de_i = 0;
        r1_addr_ex_i = 0; r2_addr_ex_i = 0; rd_addr_ex_i = 0; load_ex_i = 0; pc_sel_ex_i = 0;
        rd_addr_me_i = 0; rf_rw_me_i = 0; rd_addr_wb_i = 0; rf_rw_wb_i = 0;
        lop_issue_i = 0; lop_issue_rd_i = 0; lop_done_i = 0; lop_done_rd_i = 0;
        lop_busy_i = 0; mem_stall_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic do_reset();
        #1 rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        int nst, first_to;
        idle();
        #1;
        chk("rst_stall_de", {31'd0, stall_de_o}, 32'd0);
        chk("rst_timeout", {31'd0, hazard_timeout_o}, 32'd0);
        tick(); tick();
        rst_i = 1'b0;
        tick();

        // load-use on x5
        load_ex_i = 1; rd_addr_ex_i = 5; r1_addr_de_i = 5; #1;
        chk("lu_stall_fe", {31'd0, stall_fe_o}, 32'd1);
        chk("lu_stall_de", {31'd0, stall_de_o}, 32'd1);
        chk("lu_flush_ex", {31'd0, flush_ex_o}, 32'd1);
        tick();
        r1_addr_de_i = 5; #1;
        chk("lu_released", {31'd0, stall_de_o}, 32'd0);
        tick();
        load_ex_i = 1; rd_addr_ex_i = 0; r1_addr_de_i = 0; #1;
        chk("lu_x0", {31'd0, stall_de_o}, 32'd0);

        // EX forwarding priority
        tick();
        rf_rw_me_i = 1; rd_addr_me_i = 7; rf_rw_wb_i = 1; rd_addr_wb_i = 7;
        r1_addr_ex_i = 7; r2_addr_ex_i = 7; #1;
        chk("fwd_a_me", {30'd0, fwd_a_ex_o}, 32'd2);
        chk("fwd_b_me", {30'd0, fwd_b_ex_o}, 32'd2);
        tick();
        rf_rw_wb_i = 1; rd_addr_wb_i = 7; r1_addr_ex_i = 7; r2_addr_ex_i = 7; #1;
        chk("fwd_a_wb", {30'd0, fwd_a_ex_o}, 32'd1);
        chk("fwd_b_wb", {30'd0, fwd_b_ex_o}, 32'd1);
        tick();
        rf_rw_me_i = 1; rd_addr_me_i = 0; r1_addr_ex_i = 0; #1;
        chk("fwd_x0", {30'd0, fwd_a_ex_o}, 32'd0);

        // long op on x9, 34-cycle scoreboard stall, watchdog
        do_reset();
        lop_issue_i = 1; lop_issue_rd_i = 9;
        nst = 0; first_to = 0;
        for (int i = 1; i <= 34; i++) begin
            tick();
            r1_addr_de_i = 9; #1;
            if (stall_de_o) nst++;
            if (first_to == 0 && hazard_timeout_o) first_to = i;
`ifdef HAZARD_PERF_EN
            if (i == 11) chk("perf_10", stall_cycles_o, 32'd10);
`endif
        end
        chk("sb_hold_34", nst, 34);
        chk("wdog_rise_c11", first_to, 11);
        tick();
        r1_addr_de_i = 9; lop_done_i = 1; lop_done_rd_i = 9; rf_rw_wb_i = 1; rd_addr_wb_i = 9; #1;
        chk("done_same_cyc", {31'd0, stall_de_o}, 32'd0);
        chk("done_fwd_de", {31'd0, fwd_a_de_o}, 32'd1);
        tick();
        r1_addr_de_i = 9; #1;
        chk("pend9_clear", {31'd0, stall_de_o}, 32'd0);
        chk("wdog_sticky", {31'd0, hazard_timeout_o}, 32'd1);

        // WAW on x4 and structural stall
        tick();
        lop_issue_i = 1; lop_issue_rd_i = 4;
        tick();
        rf_rw_de_i = 1; rd_addr_de_i = 4; #1;
        chk("waw_stall", {31'd0, stall_de_o}, 32'd1);
        tick();
        lop_done_i = 1; lop_done_rd_i = 4;
        tick();
        lop_de_i = 1; lop_busy_i = 1; #1;
        chk("st_stall", {31'd0, stall_de_o}, 32'd1);
        tick();
        lop_de_i = 1; lop_busy_i = 1; pc_sel_ex_i = 1; #1;
        chk("redir_stall_flush", {30'd0, flush_de_o, stall_de_o}, 32'd3);

        // issue/done same register: set wins, then async reset mid-op
        tick();
        lop_issue_i = 1; lop_issue_rd_i = 3;
        tick();
        lop_issue_i = 1; lop_issue_rd_i = 3; lop_done_i = 1; lop_done_rd_i = 3;
        tick();
        r1_addr_de_i = 3; #1;
        chk("set_wins", {31'd0, stall_de_o}, 32'd1);
        rst_i = 1'b1; #1;
        chk("rst_midop", {31'd0, stall_de_o}, 32'd0);
        chk("rst_timeout_clr", {31'd0, hazard_timeout_o}, 32'd0);
        tick();
        rst_i = 1'b0; r1_addr_de_i = 3; #1;
        chk("rst_sb_empty", {31'd0, stall_de_o}, 32'd0);

        // redirect deferred by memory freeze
        for (int i = 0; i < 3; i++) begin
            tick();
            pc_sel_ex_i = 1; mem_stall_i = 1; #1;
            chk("frz_stalls", {28'd0, stall_fe_o, stall_de_o, stall_ex_o, stall_me_o}, 32'hF);
            chk("frz_flush", {30'd0, flush_de_o, flush_ex_o}, 32'd0);
        end
        tick();
        pc_sel_ex_i = 1; #1;
        chk("frz_lift_flush", {30'd0, flush_de_o, flush_ex_o}, 32'd3);
        tick();
        @(negedge clk_i);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout_guard actual=running required=finished");
        $fatal(1);
    end

endmodule
